alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Execute-stage driver for the 64-bit combinational ALU: takes decoded RV64I OP/OP-IMM/BRANCH
//  fields plus operands over a valid/ready handshake and produces ALU_Sel/sub/A/B. It then
//  post-processes ALU_Out/Carry_out/zero into the final result (SLT/SLTU, SRA sign fill, branch
//  outcome) and returns it with a tag over a second valid/ready handshake.
// PARAMETERS
//  XLEN   64  datapath width; must equal ALU width
//  TAG_W  5   width of pass-through tag (rd index)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      async active-low reset
//  in_valid     in   1      op request valid
//  in_ready     out  1      sequencer can accept op
//  in_funct3    in   3      RV funct3
//  in_f7b5      in   1      instr bit 30 (SUB/SRA select)
//  in_is_imm    in   1      OP-IMM form (SUB never selected)
//  in_is_branch in   1      BRANCH compare op
//  in_rs1       in   XLEN   operand A
//  in_op2       in   XLEN   operand B (rs2 or sign-extended imm)
//  in_tag       in   TAG_W  tag, returned unchanged
//  alu_a/alu_b  out  XLEN   ALU operands (registered)
//  alu_sel      out  3      ALU_Sel (registered)
//  alu_sub      out  1      ALU sub (registered)
//  alu_out      in   XLEN   ALU_Out
//  alu_carry    in   1      Carry_out
//  alu_zero     in   1      zero (sum==0)
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  out_result   out  XLEN   result
//  out_taken    out  1      branch taken (0 for non-branch)
//  out_illegal  out  1      unsupported funct3 for branch
//  out_tag      out  TAG_W  returned tag
// BEHAVIOUR
//  FSM IDLE->EXEC->HOLD. in_ready = rst_n & (state==IDLE). Accept on in_valid&in_ready: register
//   operands, tag and decoded sel/sub into alu_* -> EXEC. EXEC (1 cycle): sample ALU outputs,
//   compute out_* -> HOLD, out_valid=1 (result 2 cycles after accept edge). HOLD: out_* stable
//   until out_valid&out_ready, then IDLE. alu_* hold last value outside EXEC.
//  Decode (non-branch): 000 sel000 sub=f7b5&~is_imm; 001 sel110; 010/011 sel000 sub1;
//   100 sel100 sub0; 101 sel111 (f7b5=0) / sel101 (f7b5=1); 110 sel011; 111 sel010 sub0.
//  SLT: lt_s = (a[63]^b[63]) ? a[63] : alu_out[63]; SLTU: lt_u = ~alu_carry; result={63'b0,lt}.
//  SRA: ALU sel101 zero-fills; when a[63]=1 result = alu_out | ~({XLEN{1'b1}} >> b[5:0]).
//  Shifts use b[5:0] only. Add/sub wraps mod 2^64; carry ignored except for SLTU/branches.
//  Branch: sel000 sub1, out_result=alu_out; 000 BEQ zero; 001 BNE ~zero; 100 BLT lt_s;
//   101 BGE ~lt_s; 110 BLTU lt_u; 111 BGEU ~lt_u; 010/011 -> taken=0, out_illegal=1.
//  Reset (any state, incl. mid-EXEC/HOLD): state IDLE; out_valid, out_taken, out_illegal,
//   out_result, out_tag, alu_a, alu_b, alu_sel, alu_sub all 0; in-flight op discarded.
//  in_valid during EXEC/HOLD ignored (in_ready=0); inputs need not be held after accept.
// CONFIGURATION
//  ALU_SEQ_BACK2BACK_EN defined: in HOLD, in_ready = out_ready; same-edge result handshake plus
//   accept goes HOLD->EXEC directly, 1 op / 2 cycles. Undefined: HOLD->IDLE always,
//   1 op / 3 cycles max.
// TESTING
//  ADD rs1=0xF op2=0x3 f3=000 f7b5=0 -> EXEC alu_sel=000 sub=0; out_result=0x12, out_valid
//   at accept+2.
//  SUB 0xF-0x3 -> 0xC; SUB 5-5 -> 0; ADDI f7b5=1 0xF,0x3 -> 0x12 (sub forced 0).
//  SLT rs1=0xFFFF_FFFF_FFFF_FFFF op2=1 -> 1; SLTU same operands -> 0.
//  SRA rs1=0x8000_0000_0000_0000 op2=4 -> 0xF800_0000_0000_0000; SRL -> 0x0800_0000_0000_0000.
//  BLT -5,3 -> taken 1; BGEU 0xFFFF_FFFF_FFFF_FFFB,3 -> taken 1; BEQ 7,7 -> taken 1;
//   f3=010 branch -> taken 0, out_illegal 1.
//  out_ready=0 for 5 cycles -> out_* stable, in_ready=0; rst_n low in HOLD -> out_valid=0
//   immediately, in_ready=1 the cycle after release; with macro, continuous in_valid/out_ready
//   -> one result every 2 cycles.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - execute-stage sequencer wrapping a 64-bit combinational ALU
// Optional feature macro: ALU_SEQ_BACK2BACK_EN (accept a new op in the same cycle a result retires)
module alu_op_sequencer #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_f7b5,
  input  logic             in_is_imm,
  input  logic             in_is_branch,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_sub,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [2:0]       f3_q;
  logic             br_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             retire;
  logic [2:0]       dec_sel;
  logic             dec_sub;
  logic             lt_s;
  logic             lt_u;
  logic [XLEN-1:0]  res_n;
  logic             taken_n;
  logic             illegal_n;

  assign out_valid = (state == HOLD);
  assign retire    = out_valid & out_ready;

`ifdef ALU_SEQ_BACK2BACK_EN
  assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
`else
  assign in_ready = rst_n & (state == IDLE);
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    dec_sel = 3'b000;
    dec_sub = 1'b0;
    if (in_is_branch) begin
      dec_sub = 1'b1;
    end else begin
      case (in_funct3)
        3'b000: dec_sub = in_f7b5 & ~in_is_imm;
        3'b001: dec_sel = 3'b110;
        3'b010: dec_sub = 1'b1;
        3'b011: dec_sub = 1'b1;
        3'b100: dec_sel = 3'b100;
        3'b101: dec_sel = in_f7b5 ? 3'b101 : 3'b111;
        3'b110: dec_sel = 3'b011;
        default: dec_sel = 3'b010;
      endcase
    end
  end

  // Signed compare: differing signs decide directly, otherwise the difference sign is exact.
  assign lt_s = (alu_a[XLEN-1] ^ alu_b[XLEN-1]) ? alu_a[XLEN-1] : alu_out[XLEN-1];
  assign lt_u = ~alu_carry;

  always_comb begin
    res_n     = alu_out;
    taken_n   = 1'b0;
    illegal_n = 1'b0;
    if (br_q) begin
      case (f3_q)
        3'b000: taken_n = alu_zero;
        3'b001: taken_n = ~alu_zero;
        3'b100: taken_n = lt_s;
        3'b101: taken_n = ~lt_s;
        3'b110: taken_n = lt_u;
        3'b111: taken_n = ~lt_u;
        default: illegal_n = 1'b1;
      endcase
    end else begin
      case (f3_q)
        3'b010: res_n = {{(XLEN-1){1'b0}}, lt_s};
        3'b011: res_n = {{(XLEN-1){1'b0}}, lt_u};
        3'b101: begin
          // The ALU shifter only zero-fills; arithmetic shifts get their sign bits here.
          if (alu_sel == 3'b101 && alu_a[XLEN-1])
            res_n = alu_out | ~({XLEN{1'b1}} >> alu_b[SH_W-1:0]);
        end
        default: res_n = alu_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= 3'b000;
      alu_sub     <= 1'b0;
      f3_q        <= 3'b000;
      br_q        <= 1'b0;
      tag_q       <= '0;
      out_result  <= '0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= HOLD;
        HOLD:    if (retire) state <= accept ? EXEC : IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        alu_a   <= in_rs1;
        alu_b   <= in_op2;
        alu_sel <= dec_sel;
        alu_sub <= dec_sub;
        f3_q    <= in_funct3;
        br_q    <= in_is_branch;
        tag_q   <= in_tag;
      end

      if (state == EXEC) begin
        out_result  <= res_n;
        out_taken   <= taken_n;
        out_illegal <= illegal_n;
        out_tag     <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural ALU and result model
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic        in_is_imm;
  logic        in_is_branch;
  logic [63:0] in_rs1;
  logic [63:0] in_op2;
  logic [4:0]  in_tag;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [2:0]  alu_sel;
  logic        alu_sub;
  logic [63:0] alu_out;
  logic        alu_carry;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_taken;
  logic        out_illegal;
  logic [4:0]  out_tag;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] got_result;
  logic        got_taken;
  logic        got_illegal;

  always #5 clk = ~clk;

  alu_op_sequencer #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_is_imm(in_is_imm), .in_is_branch(in_is_branch),
    .in_rs1(in_rs1), .in_op2(in_op2), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_sub(alu_sub),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  // Combinational 64-bit ALU the sequencer drives
  logic [64:0] alu_sum;
  always_comb begin
    alu_sum   = alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1) : ({1'b0, alu_a} + {1'b0, alu_b});
    alu_carry = alu_sum[64];
    alu_zero  = (alu_sum[63:0] == 64'd0);
    case (alu_sel)
      3'b000:  alu_out = alu_sum[63:0];
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b101:  alu_out = alu_a >> alu_b[5:0];
      3'b110:  alu_out = alu_a << alu_b[5:0];
      3'b111:  alu_out = alu_a >> alu_b[5:0];
      default: alu_out = 64'd0;
    endcase
  end

  // Architectural RV64I result: {illegal, taken, result}
  function automatic logic [65:0] model(input logic [2:0] f3, input logic f7b5, input logic imm,
                                        input logic br, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic        t;
    logic        il;
    int          sh;
    sh = int'(b[5:0]);
    r  = 64'd0;
    t  = 1'b0;
    il = 1'b0;
    if (br) begin
      r = a - b;
      case (f3)
        3'b000:  t = (a == b);
        3'b001:  t = (a != b);
        3'b100:  t = ($signed(a) < $signed(b));
        3'b101:  t = ($signed(a) >= $signed(b));
        3'b110:  t = (a < b);
        3'b111:  t = (a >= b);
        default: il = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000:  r = (f7b5 && !imm) ? a - b : a + b;
        3'b001:  r = a << sh;
        3'b010:  r = {63'd0, $signed(a) < $signed(b)};
        3'b011:  r = {63'd0, a < b};
        3'b100:  r = a ^ b;
        3'b101:  r = f7b5 ? 64'($signed(a) >>> sh) : a >> sh;
        3'b110:  r = a | b;
        default: r = a & b;
      endcase
    end
    return {il, t, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic f7b5, input logic imm, input logic br,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_funct3 = f3; in_f7b5 = f7b5; in_is_imm = imm; in_is_branch = br;
    in_rs1 = a; in_op2 = b; in_tag = tag;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_rs1 = {$urandom, $urandom};
    in_op2 = {$urandom, $urandom};
  endtask

  task automatic wait_result;
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic retire_result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic f7b5, input logic imm,
                        input logic br, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    logic [65:0] exp;
    exp = model(f3, f7b5, imm, br, a, b);
    drive(f3, f7b5, imm, br, a, b, tag);
    wait_result();
    got_result  = out_result;
    got_taken   = out_taken;
    got_illegal = out_illegal;
    check({name, "_result"},  out_result, exp[63:0]);
    check({name, "_taken"},   {63'd0, out_taken}, {63'd0, exp[64]});
    check({name, "_illegal"}, {63'd0, out_illegal}, {63'd0, exp[65]});
    check({name, "_tag"},     {59'd0, out_tag}, {59'd0, tag});
    retire_result();
  endtask

  initial begin
    logic [65:0] e;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [2:0]  rf3;
    int          hs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'b000; in_f7b5 = 1'b0; in_is_imm = 1'b0; in_is_branch = 1'b0;
    in_rs1 = 64'd0; in_op2 = 64'd0; in_tag = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_alu_a",     alu_a, 64'd0);
    check("rst_alu_sel",   {61'd0, alu_sel}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // ADD with exact latency and registered ALU controls
    in_funct3 = 3'b000; in_f7b5 = 1'b0; in_is_imm = 1'b0; in_is_branch = 1'b0;
    in_rs1 = 64'hF; in_op2 = 64'h3; in_tag = 5'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("add_exec_sel",   {61'd0, alu_sel}, 64'd0);
    check("add_exec_sub",   {63'd0, alu_sub}, 64'd0);
    check("add_exec_a",     alu_a, 64'hF);
    check("add_exec_valid", {63'd0, out_valid}, 64'd0);
    check("add_exec_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_result", out_result, 64'h12);
    check("add_tag", {59'd0, out_tag}, 64'd9);
    retire_result();

    run_op("sub", 3'b000, 1'b1, 1'b0, 1'b0, 64'hF, 64'h3, 5'd1);
    check("sub_const", got_result, 64'hC);
    run_op("sub_zero", 3'b000, 1'b1, 1'b0, 1'b0, 64'd5, 64'd5, 5'd2);
    check("sub_zero_const", got_result, 64'd0);
    run_op("addi_f7", 3'b000, 1'b1, 1'b1, 1'b0, 64'hF, 64'h3, 5'd3);
    check("addi_f7_const", got_result, 64'h12);
    run_op("slt", 3'b010, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4);
    check("slt_const", got_result, 64'd1);
    run_op("sltu", 3'b011, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5);
    check("sltu_const", got_result, 64'd0);
    run_op("sra", 3'b101, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd6);
    check("sra_const", got_result, 64'hF800_0000_0000_0000);
    run_op("srl", 3'b101, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd7);
    check("srl_const", got_result, 64'h0800_0000_0000_0000);
    run_op("sll_mask", 3'b001, 1'b0, 1'b0, 1'b0, 64'd1, 64'h1_0000_0043, 5'd8);
    check("sll_mask_const", got_result, 64'd8);
    run_op("blt", 3'b100, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 5'd10);
    check("blt_const", {63'd0, got_taken}, 64'd1);
    run_op("bgeu", 3'b111, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 5'd11);
    check("bgeu_const", {63'd0, got_taken}, 64'd1);
    run_op("beq", 3'b000, 1'b0, 1'b0, 1'b1, 64'd7, 64'd7, 5'd12);
    check("beq_const", {63'd0, got_taken}, 64'd1);
    run_op("bill", 3'b010, 1'b0, 1'b0, 1'b1, 64'd7, 64'd7, 5'd13);
    check("bill_taken", {63'd0, got_taken}, 64'd0);
    check("bill_illegal", {63'd0, got_illegal}, 64'd1);

    // Consumer stall: result held, new requests ignored
    drive(3'b100, 1'b0, 1'b0, 1'b0, 64'hA5A5, 64'h0FF0, 5'd14);
    wait_result();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid",  {63'd0, out_valid}, 64'd1);
      check("stall_result", out_result, 64'hA5A5 ^ 64'h0FF0);
      check("stall_tag",    {59'd0, out_tag}, 64'd14);
      check("stall_ready",  {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    retire_result();

    // Reset while holding a result
    drive(3'b110, 1'b0, 1'b0, 1'b0, 64'h1234, 64'h8000, 5'd15);
    wait_result();
    #1 rst_n = 1'b0;
    #1;
    check("hold_rst_valid",  {63'd0, out_valid}, 64'd0);
    check("hold_rst_result", out_result, 64'd0);
    check("hold_rst_tag",    {59'd0, out_tag}, 64'd0);
    check("hold_rst_alu_b",  alu_b, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("hold_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("hold_rst_out_valid", {63'd0, out_valid}, 64'd0);

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 64'($urandom_range(0, 70));
        2:       rb = ~ra;
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) ra[63] = 1'b1;
      run_op("rand", rf3, 1'($urandom), 1'($urandom), 1'($urandom), ra, rb, 5'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Continuous traffic throughput
    e = model(3'b000, 1'b0, 1'b0, 1'b0, 64'd100, 64'd23);
    in_funct3 = 3'b000; in_f7b5 = 1'b0; in_is_imm = 1'b0; in_is_branch = 1'b0;
    in_rs1 = 64'd100; in_op2 = 64'd23; in_tag = 5'd21;
    in_valid = 1'b1; out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 24; i++) begin
      if (out_valid) begin
        hs++;
        check("stream_result", out_result, e[63:0]);
      end
      @(negedge clk);
    end
`ifdef ALU_SEQ_BACK2BACK_EN
    check("stream_count", 64'(hs), 64'd11);
`else
    check("stream_count", 64'(hs), 64'd8);
`endif
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_idle", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
